rom_reader_24x8: RTL and testbench

ROM_READER_24X8 -- requirements
Module: rom_reader_24x8

---
 rtl/rom_reader_24x8.sv | 128 ++++++++++++
 tb/tb_rom_reader_24x8.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_reader_24x8.sv
// rom_reader_24x8: reads a burst of bytes from a synchronous-select ROM and
// hands them one at a time to a downstream consumer.
//
// Consumer handshake: out_data is valid while out_valid is high and is held
// stable until the clock edge on which out_valid and out_ready are both high;
// that edge transfers the byte. out_ready is ignored while out_valid is low.
module rom_reader_24x8 #(
    parameter int ROM_DEPTH = 24,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rom_cs,
    output logic              rom_read_en,
    output logic [ADDR_W-1:0] rom_addrb,
    input  logic [7:0]        rom_datab,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(ROM_DEPTH);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remain_q;
    logic [ADDR_W:0]   req_end;
    logic              request_bad;
    logic              accept_req;
    logic              handshake;

    // Request legality: the end address is summed one bit wider so that a
    // burst running past the ROM cannot wrap back into range.
    always_comb begin
        req_end     = {1'b0, start_addr} + {1'b0, length};
        request_bad = (length == '0) || ({1'b0, start_addr} >= DEPTH) || (req_end > DEPTH);
        accept_req  = (state == IDLE) && start && !request_bad;
        handshake   = (state == OUT) && out_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs; ROM pins are parked at 0
    // outside READ so an address beyond the last byte is never presented.
    always_comb begin
        state_next  = state;
        busy        = 1'b1;
        done        = 1'b0;
        rom_cs      = 1'b0;
        rom_read_en = 1'b0;
        rom_addrb   = '0;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept_req) begin
                    state_next = READ;
                end
            end
            READ: begin
                rom_cs      = 1'b1;
                rom_read_en = 1'b1;
                rom_addrb   = addr_q;
                state_next  = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = (remain_q == ADDR_W'(1)) ? DONE : READ;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        dbg_state = state;
    end

    // Burst address/count, captured ROM byte and the rejection pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            remain_q <= '0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            err <= (state == IDLE) && start && request_bad;
            if (accept_req) begin
                addr_q   <= start_addr;
                remain_q <= length;
            end
            if (state == READ) begin
                out_data <= rom_datab;
            end
            if (handshake) begin
                remain_q <= remain_q - ADDR_W'(1);
                addr_q   <= addr_q + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rom_reader_24x8.sv
// tb_rom_reader_24x8: randomized and directed bursts against a queue-based
// reference of the bytes each legal request must deliver.
module tb_rom_reader_24x8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] start_addr;
    logic [4:0] length;
    logic       busy;
    logic       done;
    logic       err;
    logic       rom_cs;
    logic       rom_read_en;
    logic [4:0] rom_addrb;
    wire  [7:0] rom_datab;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int  cs_cnt   = 0;
    int  err_cnt  = 0;
    int  done_cnt = 0;
    int  max_addr = 0;
    bit  ready_mode = 0;
    bit  hold_prev  = 0;
    logic [7:0] held_data;

    rom_reader_24x8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rom_cs     (rom_cs),
        .rom_read_en(rom_read_en),
        .rom_addrb  (rom_addrb),
        .rom_datab  (rom_datab),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dbg_state  (dbg_state)
    );

    // ROM model: byte at address a is a ^ 8'hA5, floating when unselected.
    assign rom_datab = (rom_cs && rom_read_en) ? ({3'b000, rom_addrb} ^ 8'hA5) : 8'hzz;

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Random consumer back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (ready_mode) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_cs) begin
                cs_cnt++;
                if (int'(rom_addrb) > max_addr) max_addr = int'(rom_addrb);
            end else begin
                check("addr_parked", {27'd0, rom_addrb}, 32'd0);
            end
            if (rom_read_en !== rom_cs) check("read_en_eq_cs", {31'd0, rom_read_en}, {31'd0, rom_cs});
            if (err) err_cnt++;
            if (done) done_cnt++;
            if (hold_prev && out_valid) check("out_data_stable", {24'd0, out_data}, {24'd0, held_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_byte_queue_size", 32'd0, 32'd1);
                else check("byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
            hold_prev = out_valid && !out_ready;
            held_data = out_data;
        end else begin
            hold_prev = 0;
        end
    end

    // Reference model: legality and expected bytes from plain arithmetic.
    function automatic bit is_legal(input int a, input int l);
        return (l >= 1) && (a < 24) && (a + l <= 24);
    endfunction

    task automatic model_push(input int a, input int l);
        for (int i = 0; i < l; i++) exp_q.push_back(8'(a + i) ^ 8'hA5);
    endtask

    task automatic pulse_start(input int a, input int l);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = 5'(a);
        length     = 5'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Issue one request and check its whole outcome against the model.
    task automatic run_burst(input int a, input int l, input bit poke);
        int  e0, d0, c0;
        bit  fin;
        e0 = err_cnt; d0 = done_cnt; c0 = cs_cnt;
        if (is_legal(a, l)) model_push(a, l);
        pulse_start(a, l);
        if (!is_legal(a, l)) begin
            for (int k = 0; k < 4; k++) begin
                check("illegal_busy", {31'd0, busy}, 32'd0);
                @(posedge clk); #1;
            end
            check("illegal_err_pulses", err_cnt - e0, 1);
            check("illegal_no_rom", cs_cnt - c0, 0);
            check("illegal_no_done", done_cnt - d0, 0);
        end else begin
            fin = 0;
            for (int c = 0; c < 400 && !fin; c++) begin
                if (poke && c == 1) begin
                    start = 1'b1; start_addr = 5'd0; length = 5'd1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                if (done_cnt != d0) fin = 1;
            end
            start = 1'b0;
            check("burst_finished", {31'd0, fin}, 32'd1);
            repeat (3) @(posedge clk);
            #1;
            check("done_pulses", done_cnt - d0, 1);
            check("no_err_legal", err_cnt - e0, 0);
            check("rom_reads", cs_cnt - c0, l);
            check("queue_drained", exp_q.size(), 0);
            check("idle_after", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_cs"}, {31'd0, rom_cs}, 32'd0);
        check({tag, "_rd"}, {31'd0, rom_read_en}, 32'd0);
        check({tag, "_addr"}, {27'd0, rom_addrb}, 32'd0);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_data"}, {24'd0, out_data}, 32'd0);
    endtask

    task automatic wait_valid(output bit seen);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("wait_valid", {31'd0, seen}, 32'd1);
    endtask

    logic [7:0] t_data [0:2] = '{8'hA7, 8'hA6, 8'hA1};

    initial begin
        bit seen;
        int a, l, d0, c0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        // Cycle-exact burst at address 2, length 3, consumer always ready.
        ready_mode = 0; out_ready = 1'b1;
        d0 = done_cnt;
        model_push(2, 3);
        pulse_start(2, 3);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("t%0d_cs", k), {31'd0, rom_cs}, {31'd0, (k == 1 || k == 3 || k == 5)});
            check($sformatf("t%0d_valid", k), {31'd0, out_valid}, {31'd0, (k == 2 || k == 4 || k == 6)});
            check($sformatf("t%0d_done", k), {31'd0, done}, {31'd0, (k == 7)});
            if (k == 2 || k == 4 || k == 6) check($sformatf("t%0d_data", k), {24'd0, out_data}, {24'd0, t_data[k/2-1]});
            if (k == 8) check("data_retained", {24'd0, out_data}, 32'hA1);
            @(posedge clk); #1;
        end
        check("timing_done_once", done_cnt - d0, 1);

        // Burst ending at the last ROM byte.
        max_addr = 0;
        run_burst(21, 3, 0);
        check("max_addr", max_addr, 23);

        // Rejected requests.
        run_burst(22, 3, 0);
        run_burst(5, 0, 0);
        run_burst(24, 1, 0);

        // Consumer stall on the first byte.
        ready_mode = 0; out_ready = 1'b0;
        d0 = done_cnt;
        model_push(0, 2);
        pulse_start(0, 2);
        wait_valid(seen);
        c0 = cs_cnt;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {24'd0, out_data}, 32'hA5);
            @(posedge clk); #1;
        end
        check("stall_no_read", cs_cnt - c0, 0);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("stall_done", done_cnt - d0, 1);
        check("stall_drained", exp_q.size(), 0);

        // Reset while byte 2 of a 4-byte burst waits for the consumer.
        out_ready = 1'b0;
        model_push(10, 4);
        pulse_start(10, 4);
        for (int b = 0; b < 2; b++) begin
            wait_valid(seen);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        wait_valid(seen);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        out_ready = 1'b1;
        run_burst(5, 1, 0);

        // Start pulsed while a burst is in progress.
        ready_mode = 1;
        d0 = err_cnt;
        run_burst(3, 4, 1);
        check("busy_start_no_err", err_cnt - d0, 0);

        // Randomized requests, mostly legal.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                l = $urandom_range(1, 24);
                a = $urandom_range(0, 24 - l);
            end else begin
                l = $urandom_range(0, 31);
                a = $urandom_range(0, 31);
            end
            run_burst(a, l, $urandom_range(0, 3) == 0);
        end
        check("rand_max_addr", {31'd0, max_addr <= 23}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
